// File: rtl/qam16_symbol_source.sv
// Frame-structured 16-QAM symbol source: PRBS-15 payload, optional alternating-corner preamble.
// Preamble insertion is compiled in only when SYMBOL_PREAMBLE_EN is defined.
module qam16_symbol_source #(
  parameter int          PREAMBLE_LEN = 16,
  parameter int          FRAME_LEN    = 256,
  parameter logic [14:0] LFSR_SEED    = 15'h7FFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       enable,
  output logic [3:0] data,
  output logic       sym_valid,
  output logic       frame_start,
  output logic       in_preamble,
  output logic [1:0] state_dbg
);

  // Handshake: sym_valid is a one-clock qualifier with no back-pressure; data is
  // new exactly on sym_valid cycles and held stable otherwise.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam logic [15:0] FRAME_END = 16'(FRAME_LEN);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [14:0] lfsr, lfsr_nxt, lfsr_adv;
  logic [3:0]  prbs, data_nxt;
  logic        valid_nxt, fs_nxt;

  assign state_dbg = state;

`ifdef SYMBOL_PREAMBLE_EN
  localparam logic [15:0] PRE_END = 16'(PREAMBLE_LEN);
  logic pre_q, pre_nxt;
  assign in_preamble = pre_q;
`else
  assign in_preamble = 1'b0;
`endif

  // Four LFSR steps per symbol; the first feedback bit lands in data[3].
  always_comb begin : lfsr_four_steps
    logic [14:0] s;
    logic        fb;
    s    = lfsr;
    fb   = 1'b0;
    prbs = '0;
    for (int i = 0; i < 4; i++) begin
      fb   = s[14] ^ s[13];
      prbs = {prbs[2:0], fb};
      s    = {s[13:0], fb};
    end
    lfsr_adv = s;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    data_nxt  = data;
    valid_nxt = 1'b0;
    fs_nxt    = 1'b0;
`ifdef SYMBOL_PREAMBLE_EN
    pre_nxt   = pre_q;
`endif
    if (clk_en) begin
      if (!enable) begin
        // Abort: the LFSR keeps its position so a restart continues the sequence.
        state_nxt = IDLE;
        cnt_nxt   = '0;
`ifdef SYMBOL_PREAMBLE_EN
        pre_nxt   = 1'b0;
`endif
      end else begin
        valid_nxt = 1'b1;
        case (state)
`ifdef SYMBOL_PREAMBLE_EN
          IDLE: begin
            state_nxt = PREAMBLE;
            data_nxt  = 4'h0;
            fs_nxt    = 1'b1;
            pre_nxt   = 1'b1;
            cnt_nxt   = 16'd1;
          end
          PREAMBLE: begin
            if (cnt == PRE_END) begin
              state_nxt = PAYLOAD;
              data_nxt  = prbs;
              lfsr_nxt  = lfsr_adv;
              pre_nxt   = 1'b0;
              cnt_nxt   = 16'd1;
            end else begin
              data_nxt = cnt[0] ? 4'hA : 4'h0;
              cnt_nxt  = cnt + 16'd1;
            end
          end
          default: begin
            if (cnt == FRAME_END) begin
              state_nxt = PREAMBLE;
              data_nxt  = 4'h0;
              fs_nxt    = 1'b1;
              pre_nxt   = 1'b1;
              cnt_nxt   = 16'd1;
            end else begin
              data_nxt = prbs;
              lfsr_nxt = lfsr_adv;
              cnt_nxt  = cnt + 16'd1;
            end
          end
`else
          PAYLOAD: begin
            data_nxt = prbs;
            lfsr_nxt = lfsr_adv;
            if (cnt == FRAME_END) begin
              fs_nxt  = 1'b1;
              cnt_nxt = 16'd1;
            end else begin
              cnt_nxt = cnt + 16'd1;
            end
          end
          default: begin
            state_nxt = PAYLOAD;
            data_nxt  = prbs;
            lfsr_nxt  = lfsr_adv;
            fs_nxt    = 1'b1;
            cnt_nxt   = 16'd1;
          end
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      data        <= '0;
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef SYMBOL_PREAMBLE_EN
      pre_q       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lfsr        <= lfsr_nxt;
      data        <= data_nxt;
      sym_valid   <= valid_nxt;
      frame_start <= fs_nxt;
`ifdef SYMBOL_PREAMBLE_EN
      pre_q       <= pre_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_qam16_symbol_source.sv
// Scoreboard bench for qam16_symbol_source: frame-position reference model feeds exp_q,
// a negedge monitor pops and compares on every sym_valid.
module tb_qam16_symbol_source;

`ifdef SYMBOL_PREAMBLE_EN
  localparam int PRE     = 16;
  localparam int FL      = 256;
  localparam int PRE_EFF = PRE;
`else
  localparam int PRE     = 16;
  localparam int FL      = 8;
  localparam int PRE_EFF = 0;
`endif
  localparam logic [14:0] SEED = 15'h7FFF;
  localparam int PERIOD  = PRE_EFF + FL;
  localparam int DROP_AT = (FL > 10) ? 10 : FL / 2;

  logic       clk, reset_n, clk_en, enable;
  logic [3:0] data;
  logic       sym_valid, frame_start, in_preamble;
  logic [1:0] state_dbg;

  qam16_symbol_source #(
    .PREAMBLE_LEN(PRE),
    .FRAME_LEN   (FL),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .enable     (enable),
    .data       (data),
    .sym_valid  (sym_valid),
    .frame_start(frame_start),
    .in_preamble(in_preamble),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];   // {data, frame_start, in_preamble}
  logic [3:0] obs_q[$];   // payload symbols as seen at the DUT output

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame viewed as positions 0..PERIOD-1; positions below PRE_EFF are preamble.
  bit         running;
  int         pos;
  logic [14:0] m_lfsr;
  bit         bitstream[$];

  task automatic model_reset();
    running = 0;
    pos     = 0;
    m_lfsr  = SEED;
    bitstream.delete();
  endtask

  task automatic refill_bits();
    bit nb;
    while (bitstream.size() < 4) begin
      nb     = m_lfsr[14] ^ m_lfsr[13];
      m_lfsr = {m_lfsr[13:0], nb};
      bitstream.push_back(nb);
    end
  endtask

  task automatic model_step(input logic en);
    logic [3:0] d;
    logic       ip;
    if (!en) begin
      running = 0;
      return;
    end
    if (!running) begin
      running = 1;
      pos     = 0;
    end
    if (pos < PRE_EFF) begin
      d  = (pos % 2 == 1) ? 4'hA : 4'h0;
      ip = 1'b1;
    end else begin
      refill_bits();
      d[3] = bitstream.pop_front();
      d[2] = bitstream.pop_front();
      d[1] = bitstream.pop_front();
      d[0] = bitstream.pop_front();
      ip   = 1'b0;
    end
    exp_q.push_back({d, (pos == 0), ip});
    pos = (pos + 1) % PERIOD;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; leaves the bench at posedge+1 after gap clocks.
  task automatic strobe(input logic en, input int gap);
    clk_en = 1'b1;
    enable = en;
    model_step(en);
    @(posedge clk); #1;
    clk_en = 1'b0;
    for (int i = 1; i < gap; i++) begin
      enable = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_to(input int target, input int gap, input string name);
    int k;
    k = 0;
    while (!(running && pos == target) && k < 2000) begin
      strobe(1'b1, gap);
      k++;
    end
    check(name, (running && pos == target), 1);
  endtask

  task automatic settle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  logic [3:0] last_data = '0;
  int         since_fs  = 0;
  int         last_gap  = -1;
  int         n_valid   = 0;

  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset_n) begin
      last_data = '0;
      since_fs  = 0;
    end else begin
      if (sym_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_sym_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", data, e[5:2]);
          check("frame_start", frame_start, e[1]);
          check("in_preamble", in_preamble, e[0]);
        end
        if (frame_start) begin
          last_gap = since_fs;
          since_fs = 1;
        end else begin
          since_fs++;
        end
        if (!in_preamble) obs_q.push_back(data);
      end else begin
        check("idle_frame_start", frame_start, 0);
        check("data_hold", data, last_data);
      end
      last_data = data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    reset_n = 1'b0;
    clk_en  = 1'b0;
    enable  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_in_preamble", in_preamble, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Undisturbed run: one full frame plus the start of the next.
    for (int i = 0; i < PERIOD + PRE_EFF + 4; i++) strobe(1'b1, 4);
    settle();
    check("frame_gap", last_gap, PERIOD);
    check("first_payload_count", obs_q.size() >= 4, 1);
    if (obs_q.size() >= 4) begin
      check("payload1", obs_q[0], 4'h0);
      check("payload2", obs_q[1], 4'h0);
      check("payload3", obs_q[2], 4'h0);
      check("payload4", obs_q[3], 4'h2);
    end

    // Drop enable mid-payload for three strobes, then restart.
    run_to(PRE_EFF + DROP_AT, 2, "reach_drop_point");
    for (int i = 0; i < 3; i++) strobe(1'b0, $urandom_range(1, 3));
    for (int i = 0; i < PRE_EFF + 6; i++) strobe(1'b1, $urandom_range(1, 3));

    // Back-to-back strobes, then a long clk_en-low hold.
    settle();
    n0 = n_valid;
    for (int i = 0; i < 39; i++) strobe(1'b1, 1);
    strobe(1'b1, 21);
    settle();
    check("back_to_back_count", n_valid - n0, 40);

    // Asynchronous reset in the middle of a frame.
    run_to(5, 1, "reach_reset_point");
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", data, 0);
    check("async_rst_sym_valid", sym_valid, 0);
    check("async_rst_frame_start", frame_start, 0);
    check("async_rst_in_preamble", in_preamble, 0);
    check("async_rst_pending", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    obs_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < PRE_EFF + 6; i++) strobe(1'b1, $urandom_range(1, 4));
    settle();
    check("post_rst_payload_count", obs_q.size() >= 4, 1);
    if (obs_q.size() >= 4) begin
      check("post_rst_payload1", obs_q[0], 4'h0);
      check("post_rst_payload2", obs_q[1], 4'h0);
      check("post_rst_payload3", obs_q[2], 4'h0);
      check("post_rst_payload4", obs_q[3], 4'h2);
    end

    // Randomised enable and strobe spacing.
    for (int i = 0; i < 400; i++)
      strobe(($urandom_range(0, 9) != 0), $urandom_range(1, 3));

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
